etapa_if_param: RTL and testbench

- Parametrised instruction-fetch stage for the vector processor.
- Selects an algorithm start address from a parameter table on a start request, then fetches sequentially from an external synchronous ROM. Supports stall, taken branch (with squash), abort, and halt-word detection.
- Sits between the control unit (start/alg_sel/abort) and the decode stage (instr/instr_valid, stall, branch).

---
 rtl/etapa_if_param.sv | 134 +++++++++++++
 tb/tb_etapa_if_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_if_param.sv
// Instruction-fetch stage. On start it picks an algorithm's first address from
// a parameter table, then fetches that algorithm sequentially from an external
// synchronous ROM. Decode can stall the fetch, redirect it with a taken branch,
// or the control unit can abort it. A fetched HALT_WORD ends the algorithm.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, alg_sel      begin algorithm alg_sel (sampled only while idle)
//   abort               return to idle immediately, no done pulse
//   stall               decode back-pressure, freezes the fetch
//   branch_taken/target redirect from decode (ignored while stalled)
//   rom_addr, rom_data  ROM port, one-cycle read latency
//   instr, instr_valid, instr_pc   instruction presented to decode
//   busy                running an algorithm
//   done                one-cycle pulse after the halt word is consumed
//   err                 one-cycle pulse when start names an unknown algorithm
module etapa_if_param #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned INSTR_W = 14,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_ALG = 8,
  parameter logic [NUM_ALG*PC_W-1:0] ALG_TABLE =
    {6'd29, 6'd20, 6'd16, 6'd12, 6'd8, 6'd4, 6'd0, 6'd0},
  parameter logic [INSTR_W-1:0] HALT_WORD = 14'h3FFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SEL_W-1:0]   alg_sel,
  input  logic               abort,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;        // address being issued to the ROM
  logic [PC_W-1:0]   instr_pc_q;  // address of the word now on rom_data
  logic              vld_q;       // rom_data holds a live (non-squashed) fetch
  logic              done_q;
  logic              err_q;

  logic              sel_ok;
  logic              is_halt;
  logic              halt_hit;

  // Start address of algorithm sel; unknown indices return zero (never used).
  function automatic logic [PC_W-1:0] start_addr(input logic [SEL_W-1:0] sel);
    logic [PC_W-1:0] a;
    a = '0;
    for (int unsigned k = 0; k < NUM_ALG; k++) begin
      if (sel == SEL_W'(k)) a = ALG_TABLE[k*PC_W +: PC_W];
    end
    return a;
  endfunction

  assign sel_ok   = (32'(alg_sel) < NUM_ALG);
  assign is_halt  = (rom_data == HALT_WORD);
  assign halt_hit = vld_q && is_halt && !stall;

  // While stalled the ROM re-reads the presented address so instr holds steady.
  assign rom_addr    = (state_q == S_RUN && stall) ? instr_pc_q : pc_q;
  assign instr       = rom_data;
  assign instr_valid = vld_q && !is_halt && (state_q == S_RUN);
  assign instr_pc    = instr_pc_q;
  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign err         = err_q;

  // Fetch control: priority abort > halt > branch > stall > sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          vld_q <= 1'b0;
          if (start) begin
            if (sel_ok) begin
              pc_q    <= start_addr(alg_sel);
              state_q <= S_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
          end else if (halt_hit) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
          end else if (branch_taken && !stall) begin
            // The word fetched from pc_q arrives next cycle and is squashed.
            pc_q       <= branch_target;
            instr_pc_q <= pc_q;
            vld_q      <= 1'b0;
          end else if (!stall) begin
            instr_pc_q <= pc_q;
            pc_q       <= pc_q + PC_W'(1);
            vld_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_if_param.sv
// Directed bench for etapa_if_param: a default instance plus a NUM_ALG=6
// instance for the unknown-algorithm error. ROM word at address a is
// 14'h1000|a except address 6, which holds the halt word.
module tb_etapa_if_param;

  localparam int unsigned PC_W    = 6;
  localparam int unsigned INSTR_W = 14;
  localparam int unsigned SEL_W   = 3;
  localparam logic [INSTR_W-1:0] HALT = 14'h3FFF;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [SEL_W-1:0]   alg_sel;
  logic               abort;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    instr_pc;
  logic               busy;
  logic               done;
  logic               err;

  logic               start6;
  logic [SEL_W-1:0]   alg_sel6;
  logic [PC_W-1:0]    rom_addr6;
  logic [INSTR_W-1:0] rom_data6;
  logic [INSTR_W-1:0] instr6;
  logic               instr_valid6;
  logic [PC_W-1:0]    instr_pc6;
  logic               busy6;
  logic               done6;
  logic               err6;

  logic [INSTR_W-1:0] rom [64];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data6 <= rom[rom_addr6];
  end

  etapa_if_param u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alg_sel(alg_sel), .abort(abort),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .busy(busy), .done(done),
    .err(err)
  );

  etapa_if_param #(
    .NUM_ALG(6),
    .ALG_TABLE({6'd20, 6'd16, 6'd12, 6'd8, 6'd4, 6'd0})
  ) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .alg_sel(alg_sel6), .abort(1'b0),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(6'd0),
    .rom_addr(rom_addr6), .rom_data(rom_data6), .instr(instr6),
    .instr_valid(instr_valid6), .instr_pc(instr_pc6), .busy(busy6), .done(done6),
    .err(err6)
  );

  function automatic logic [31:0] rv(input int a);
    return 32'h1000 + 32'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 14'h1000 | 14'(i);
    rom[6] = HALT;
    rst_n = 1'b0; start = 1'b0; alg_sel = '0; abort = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; start6 = 1'b0; alg_sel6 = '0;

    // Reset state
    tick(); settle();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_addr",  32'(rom_addr), 0);
    chk("rst_pc",    32'(instr_pc), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    rst_n = 1'b1;
    tick();

    // Algorithm 2: A, B, halt
    start = 1'b1; alg_sel = 3'd2; settle();
    chk("a_idle_busy", 32'(busy), 0);
    tick(); start = 1'b0; settle();
    chk("a_c1_busy",  32'(busy), 1);
    chk("a_c1_addr",  32'(rom_addr), 4);
    chk("a_c1_valid", 32'(instr_valid), 0);
    tick(); settle();
    chk("a_c2_addr",  32'(rom_addr), 5);
    chk("a_c2_valid", 32'(instr_valid), 1);
    chk("a_c2_pc",    32'(instr_pc), 4);
    chk("a_c2_instr", 32'(instr), rv(4));
    tick(); settle();
    chk("a_c3_addr",  32'(rom_addr), 6);
    chk("a_c3_valid", 32'(instr_valid), 1);
    chk("a_c3_pc",    32'(instr_pc), 5);
    chk("a_c3_instr", 32'(instr), rv(5));
    tick(); settle();
    chk("a_halt_addr",  32'(rom_addr), 7);
    chk("a_halt_valid", 32'(instr_valid), 0);
    chk("a_halt_busy",  32'(busy), 1);
    chk("a_halt_done",  32'(done), 0);
    tick(); settle();
    chk("a_done_pulse", 32'(done), 1);
    chk("a_done_busy",  32'(busy), 0);
    chk("a_done_valid", 32'(instr_valid), 0);
    tick(); settle();
    chk("a_done_clear", 32'(done), 0);

    // Algorithm 7 at 29, branch to 63, wrap to 0, then abort
    start = 1'b1; alg_sel = 3'd7; tick(); start = 1'b0; settle();
    chk("b_c1_addr", 32'(rom_addr), 29);
    tick(); settle();
    chk("b_c2_pc",    32'(instr_pc), 29);
    chk("b_c2_instr", 32'(instr), rv(29));
    chk("b_c2_valid", 32'(instr_valid), 1);
    chk("b_c2_err",   32'(err), 0);
    branch_taken = 1'b1; branch_target = 6'd63;
    tick(); branch_taken = 1'b0; settle();
    chk("b_sq_valid", 32'(instr_valid), 0);
    chk("b_sq_addr",  32'(rom_addr), 63);
    chk("b_sq_pc",    32'(instr_pc), 30);
    tick(); settle();
    chk("b_wrap_addr",  32'(rom_addr), 0);
    chk("b_wrap_valid", 32'(instr_valid), 1);
    chk("b_wrap_pc",    32'(instr_pc), 63);
    chk("b_wrap_instr", 32'(instr), rv(63));
    tick(); settle();
    chk("b_zero_pc",    32'(instr_pc), 0);
    chk("b_zero_instr", 32'(instr), rv(0));
    chk("b_zero_err",   32'(err), 0);
    abort = 1'b1; tick(); abort = 1'b0; settle();
    chk("b_abort_busy",  32'(busy), 0);
    chk("b_abort_valid", 32'(instr_valid), 0);
    chk("b_abort_done",  32'(done), 0);
    tick(); settle();
    chk("b_abort_done2", 32'(done), 0);

    // Algorithm 6 at 20, 3-cycle stall on instr_pc 21
    start = 1'b1; alg_sel = 3'd6; tick(); start = 1'b0; settle();
    chk("c_c1_addr", 32'(rom_addr), 20);
    tick(); settle();
    chk("c_c2_pc", 32'(instr_pc), 20);
    tick(); stall = 1'b1; settle();
    for (int s = 1; s <= 3; s++) begin
      chk($sformatf("c_stall%0d_addr", s),  32'(rom_addr), 21);
      chk($sformatf("c_stall%0d_instr", s), 32'(instr), rv(21));
      chk($sformatf("c_stall%0d_pc", s),    32'(instr_pc), 21);
      chk($sformatf("c_stall%0d_valid", s), 32'(instr_valid), 1);
      if (s < 3) begin
        tick(); settle();
      end
    end
    tick(); stall = 1'b0; settle();
    chk("c_rel_addr",  32'(rom_addr), 22);
    chk("c_rel_pc",    32'(instr_pc), 21);
    chk("c_rel_instr", 32'(instr), rv(21));
    tick(); settle();
    chk("c_next_pc",    32'(instr_pc), 22);
    chk("c_next_instr", 32'(instr), rv(22));
    chk("c_next_addr",  32'(rom_addr), 23);
    abort = 1'b1; tick(); abort = 1'b0;

    // Algorithm 3 at 8: stalled branch ignored, then branch to 12 squashes 9
    start = 1'b1; alg_sel = 3'd3; tick(); start = 1'b0; settle();
    chk("d_c1_addr", 32'(rom_addr), 8);
    tick(); stall = 1'b1; branch_taken = 1'b1; branch_target = 6'd12; settle();
    chk("d_st_pc",   32'(instr_pc), 8);
    chk("d_st_addr", 32'(rom_addr), 8);
    tick(); stall = 1'b0; settle();
    chk("d_ign_addr",  32'(rom_addr), 9);
    chk("d_ign_pc",    32'(instr_pc), 8);
    chk("d_ign_valid", 32'(instr_valid), 1);
    tick(); branch_taken = 1'b0; settle();
    chk("d_sq_valid", 32'(instr_valid), 0);
    chk("d_sq_pc",    32'(instr_pc), 9);
    chk("d_sq_addr",  32'(rom_addr), 12);
    tick(); settle();
    chk("d_tgt_pc",    32'(instr_pc), 12);
    chk("d_tgt_valid", 32'(instr_valid), 1);
    chk("d_tgt_instr", 32'(instr), rv(12));
    chk("d_tgt_addr",  32'(rom_addr), 13);
    abort = 1'b1; stall = 1'b1; start = 1'b1; alg_sel = 3'd2;
    tick(); abort = 1'b0; stall = 1'b0; start = 1'b0; settle();
    chk("d_abort_busy",  32'(busy), 0);
    chk("d_abort_valid", 32'(instr_valid), 0);
    chk("d_abort_done",  32'(done), 0);
    tick(); settle();
    chk("d_norestart_busy", 32'(busy), 0);

    // Reset mid-run, then a normal restart
    start = 1'b1; alg_sel = 3'd4; tick(); start = 1'b0; tick(); settle();
    chk("e_pre_valid", 32'(instr_valid), 1);
    chk("e_pre_pc",    32'(instr_pc), 12);
    rst_n = 1'b0; settle();
    chk("e_rst_valid", 32'(instr_valid), 0);
    chk("e_rst_busy",  32'(busy), 0);
    chk("e_rst_addr",  32'(rom_addr), 0);
    chk("e_rst_done",  32'(done), 0);
    chk("e_rst_err",   32'(err), 0);
    tick(); rst_n = 1'b1; tick();
    start = 1'b1; alg_sel = 3'd2; tick(); start = 1'b0; settle();
    chk("e_c1_addr", 32'(rom_addr), 4);
    tick(); settle();
    chk("e_c2_valid", 32'(instr_valid), 1);
    chk("e_c2_instr", 32'(instr), rv(4));
    tick(); tick(); tick(); settle();
    chk("e_done", 32'(done), 1);

    // NUM_ALG=6 instance: index 7 is unknown, index 5 starts at 20
    start6 = 1'b1; alg_sel6 = 3'd7; tick(); start6 = 1'b0; settle();
    chk("f_err_pulse", 32'(err6), 1);
    chk("f_err_busy",  32'(busy6), 0);
    tick(); settle();
    chk("f_err_clear", 32'(err6), 0);
    chk("f_err_idle",  32'(busy6), 0);
    start6 = 1'b1; alg_sel6 = 3'd5; tick(); start6 = 1'b0; settle();
    chk("f_ok_busy", 32'(busy6), 1);
    chk("f_ok_err",  32'(err6), 0);
    chk("f_ok_addr", 32'(rom_addr6), 20);
    tick(); settle();
    chk("f_ok_valid", 32'(instr_valid6), 1);
    chk("f_ok_pc",    32'(instr_pc6), 20);
    chk("f_ok_instr", 32'(instr6), rv(20));
    chk("f_ok_done",  32'(done6), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
